// File: rtl/fifo_umbral_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_umbral_if
// Brief    : Bus bundle for fifo_umbral (config, push/pop handshake, status).
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_umbral_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
);
    logic                  cfg_load;
    logic [7:0]            umbral_bajo;
    logic [7:0]            umbral_alto;
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  error;

    modport master (
        output cfg_load, umbral_bajo, umbral_alto, push, data_in, pop,
        input  data_out, valid_out, empty, full, almost_empty, almost_full,
               count, error
    );

    modport slave (
        input  cfg_load, umbral_bajo, umbral_alto, push, data_in, pop,
        output data_out, valid_out, empty, full, almost_empty, almost_full,
               count, error
    );
endinterface
`default_nettype wire

// File: rtl/fifo_umbral.sv
`default_nettype none
// ============================================================================
// Module   : fifo_umbral
// Brief    : Single-clock FIFO with programmable almost-empty/almost-full
//            thresholds and overflow/underflow error reporting.
//            Optional macro FIFO_STICKY_ERR_EN makes error sticky until reset.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fifo_umbral_if.slave       bus
);
    localparam int                  c_DEPTH_INT = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH     = (ADDR_WIDTH+1)'(c_DEPTH_INT);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH_INT];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [7:0]            r_bajo;
    logic [7:0]            r_alto;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_error;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic                  w_overflow;
    logic                  w_underflow;
    logic [7:0]            w_count_ext;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_DEPTH);
    assign w_count_ext = 8'(r_count);

    // A pop on a full FIFO frees the slot the concurrent push needs.
    assign w_pop_ok    = bus.pop & ~w_empty;
    assign w_push_ok   = bus.push & (~w_full | w_pop_ok);
    assign w_overflow  = bus.push & w_full & ~w_pop_ok;
    assign w_underflow = bus.pop & w_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok && !reset) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_bajo      <= '0;
            r_alto      <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (bus.cfg_load) begin
                r_bajo <= bus.umbral_bajo;
                r_alto <= bus.umbral_alto;
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            r_valid_out <= w_pop_ok;
            if (w_pop_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
`ifdef FIFO_STICKY_ERR_EN
            r_error <= r_error | w_overflow | w_underflow;
`else
            r_error <= w_overflow | w_underflow;
`endif
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.valid_out    = r_valid_out;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_empty = (w_count_ext <= r_bajo);
    assign bus.almost_full  = (w_count_ext >= r_alto);
    assign bus.count        = r_count;
    assign bus.error        = r_error;
endmodule
`default_nettype wire

// File: tb/tb_fifo_umbral.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_umbral
// Brief    : Directed self-checking bench for fifo_umbral.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_umbral;
    localparam int c_DW = 6;
    localparam int c_AW = 3;
`ifdef FIFO_STICKY_ERR_EN
    localparam int c_STICKY = 1;
`else
    localparam int c_STICKY = 0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    fifo_umbral_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) bus ();

    fifo_umbral #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // Advance one edge; outputs are then stable for checking and inputs may change.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cfg_load = 1'b0;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.data_in  = '0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.umbral_bajo = 8'd0;
        bus.umbral_alto = 8'd0;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state: thresholds are 0, so almost_full reads 1.
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_aempty", int'(bus.almost_empty), 1);
        chk("rst_afull", int'(bus.almost_full), 1);
        chk("rst_valid", int'(bus.valid_out), 0);
        chk("rst_error", int'(bus.error), 0);
        chk("rst_dout", int'(bus.data_out), 0);

        // Thresholds bajo=2, alto=6, then fill 1..6.
        bus.cfg_load    = 1'b1;
        bus.umbral_bajo = 8'd2;
        bus.umbral_alto = 8'd6;
        step();
        bus.cfg_load = 1'b0;
        chk("cfg_afull_cnt0", int'(bus.almost_full), 0);
        chk("cfg_count", int'(bus.count), 0);
        for (int k = 1; k <= 6; k++) begin
            bus.push    = 1'b1;
            bus.data_in = c_DW'(k);
            step();
            chk($sformatf("thr_count%0d", k), int'(bus.count), k);
            chk($sformatf("thr_aempty%0d", k), int'(bus.almost_empty), (k <= 2) ? 1 : 0);
            chk($sformatf("thr_afull%0d", k), int'(bus.almost_full), (k >= 6) ? 1 : 0);
        end
        bus.push = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            bus.pop = 1'b1;
            step();
            chk($sformatf("thr_pop_valid%0d", k), int'(bus.valid_out), 1);
            chk($sformatf("thr_pop_data%0d", k), int'(bus.data_out), k);
        end
        bus.pop = 1'b0;
        step();
        chk("thr_drained_empty", int'(bus.empty), 1);
        chk("thr_idle_valid", int'(bus.valid_out), 0);

        // Fill 0x10..0x17, then an overflowing push of 0x3F.
        for (int k = 0; k < 8; k++) begin
            bus.push    = 1'b1;
            bus.data_in = c_DW'(8'h10 + k);
            step();
        end
        chk("fill_full", int'(bus.full), 1);
        chk("fill_count", int'(bus.count), 8);
        chk("fill_error", int'(bus.error), 0);
        bus.data_in = 6'h3F;
        step();
        chk("ovf_error", int'(bus.error), 1);
        chk("ovf_count", int'(bus.count), 8);
        bus.push = 1'b0;
        step();
        chk("ovf_error_after", int'(bus.error), c_STICKY);

        // Full FIFO with push+pop for 4 cycles.
        for (int k = 0; k < 4; k++) begin
            bus.push    = 1'b1;
            bus.pop     = 1'b1;
            bus.data_in = c_DW'(8'h20 + k);
            step();
            chk($sformatf("pp_count%0d", k), int'(bus.count), 8);
            chk($sformatf("pp_error%0d", k), int'(bus.error), c_STICKY);
            chk($sformatf("pp_valid%0d", k), int'(bus.valid_out), 1);
            chk($sformatf("pp_data%0d", k), int'(bus.data_out), 8'h10 + k);
        end
        bus.push = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.pop = 1'b1;
            step();
            chk($sformatf("wrap_valid%0d", k), int'(bus.valid_out), 1);
            chk($sformatf("wrap_data%0d", k), int'(bus.data_out),
                (k < 4) ? (8'h14 + k) : (8'h20 + k - 4));
        end
        chk("wrap_empty", int'(bus.empty), 1);
        bus.pop = 1'b0;
        step();
        chk("hold_valid", int'(bus.valid_out), 0);
        chk("hold_data", int'(bus.data_out), 8'h23);

        // Underflow, then push+pop on empty with 0x2A.
        bus.pop = 1'b1;
        step();
        chk("udf_error", int'(bus.error), 1);
        chk("udf_valid", int'(bus.valid_out), 0);
        chk("udf_count", int'(bus.count), 0);
        bus.push    = 1'b1;
        bus.data_in = 6'h2A;
        step();
        chk("epp_error", int'(bus.error), 1);
        chk("epp_valid", int'(bus.valid_out), 0);
        chk("epp_count", int'(bus.count), 1);
        idle_inputs();
        step();
        chk("udf_error_after", int'(bus.error), c_STICKY);
        chk("epp_nobypass_valid", int'(bus.valid_out), 0);
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
        chk("epp_pop_valid", int'(bus.valid_out), 1);
        chk("epp_pop_data", int'(bus.data_out), 8'h2A);
        chk("epp_pop_empty", int'(bus.empty), 1);

        // Reset mid-stream at count 5 with push held high.
        for (int k = 0; k < 5; k++) begin
            bus.push    = 1'b1;
            bus.data_in = c_DW'(k + 1);
            step();
        end
        chk("mid_count", int'(bus.count), 5);
        bus.pop = 1'b1;
        reset   = 1'b1;
        step();
        chk("mrst_count", int'(bus.count), 0);
        chk("mrst_empty", int'(bus.empty), 1);
        chk("mrst_afull", int'(bus.almost_full), 1);
        chk("mrst_aempty", int'(bus.almost_empty), 1);
        chk("mrst_valid", int'(bus.valid_out), 0);
        chk("mrst_error", int'(bus.error), 0);
        reset = 1'b0;
        idle_inputs();
        step();
        chk("mrst_count_after", int'(bus.count), 0);
        chk("mrst_dout", int'(bus.data_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
